input_buffer_sched: RTL and testbench



---
 rtl/ib_sched_pkg.sv | 16 +
 rtl/input_buffer_sched_if.sv | 28 ++
 rtl/ib_ring_mem.sv | 35 +++
 rtl/input_buffer_sched.sv | 142 ++++++++++++++
 tb/tb_input_buffer_sched.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ib_sched_pkg.sv
// Shared types and helpers for the trace input buffer scheduler.
package ib_sched_pkg;

  // Capture sequencing: idle, accepting from the model, or draining what is stored.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } ib_state_t;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/input_buffer_sched_if.sv
// Stream-side signals of the input buffer: the non-stallable source and the
// downstream valid/ready consumer.
interface input_buffer_sched_if #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                           valid_in;
  logic                           eof_in;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_in;
  logic                           ready_in;
  logic                           valid_out;
  logic                           eof_out;
  logic [N-1:0][DATA_WIDTH-1:0]   vector_out;

  // Environment side: drives the source and the downstream ready.
  modport master (
    output valid_in, eof_in, vector_in, ready_in,
    input  valid_out, eof_out, vector_out
  );

  // Buffer side.
  modport slave (
    input  valid_in, eof_in, vector_in, ready_in,
    output valid_out, eof_out, vector_out
  );

endinterface

// File: rtl/ib_ring_mem.sv
// Ring storage: Depth slots of vector data plus a parallel eof bit array,
// written synchronously and read asynchronously at the head pointer.
module ib_ring_mem #(
  parameter int unsigned Width = 256,
  parameter int unsigned Depth = 4,
  parameter int unsigned PtrW  = 2
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [PtrW-1:0]  wr_ptr_i,
  input  logic             wr_eof_i,
  input  logic [Width-1:0] wr_vec_i,
  input  logic [PtrW-1:0]  rd_ptr_i,
  output logic             rd_eof_o,
  output logic [Width-1:0] rd_vec_o
);

  logic [Width-1:0] vec_q [Depth];
  logic             eof_q [Depth];

  // Storage is not reset; the owner qualifies the head with its own count.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      vec_q[wr_ptr_i] <= wr_vec_i;
      eof_q[wr_ptr_i] <= wr_eof_i;
    end
  end

  // Show-ahead head read.
  always_comb begin
    rd_vec_o = vec_q[rd_ptr_i];
    rd_eof_o = eof_q[rd_ptr_i];
  end

endmodule

// File: rtl/input_buffer_sched.sv
// Input buffer scheduler: absorbs vectors from a never-stalling source, holds the
// last slot back for eof so frame boundaries survive overflow, and drains to a
// valid/ready consumer.
module input_buffer_sched
  import ib_sched_pkg::*;
#(
  parameter int unsigned N              = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned IB_DEPTH       = 4,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              enable_in,
  input_buffer_sched_if.slave               bus,
  output logic [occ_width(IB_DEPTH)-1:0]    occupancy_out,
  output logic [DROP_CNT_WIDTH-1:0]         drop_count_out,
  output logic                              overflow_out,
  output logic                              frame_done_out
);

  localparam int unsigned OccW = occ_width(IB_DEPTH);
  localparam int unsigned PtrW = (IB_DEPTH > 1) ? $clog2(IB_DEPTH) : 1;
  localparam int unsigned VecW = N * DATA_WIDTH;

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  ib_state_t                 state_q, state_d;
  logic [OccW-1:0]           count_q, count_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      overflow_q, overflow_d;
  logic                      frame_done_q, frame_done_d;

  logic            head_valid, head_eof, pop, push, drop, accept_ok, in_run;
  logic [OccW-1:0] count_eff;
  logic [VecW-1:0] head_vec;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(IB_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  ib_ring_mem #(
    .Width (VecW),
    .Depth (IB_DEPTH),
    .PtrW  (PtrW)
  ) u_mem (
    .clk_i    (clk_in),
    .wr_en_i  (push),
    .wr_ptr_i (wr_ptr_q),
    .wr_eof_i (bus.eof_in),
    .wr_vec_i (bus.vector_in),
    .rd_ptr_i (rd_ptr_q),
    .rd_eof_o (head_eof),
    .rd_vec_o (head_vec)
  );

  // Handshake, accept/drop decision; non-eof vectors may never take the last free slot.
  always_comb begin
    head_valid = (count_q != '0);
    pop        = head_valid && bus.ready_in;
    count_eff  = count_q - OccW'(pop);
    accept_ok  = bus.eof_in ? (count_eff < OccW'(IB_DEPTH))
                            : (count_eff < OccW'(IB_DEPTH - 1));
    in_run     = (state_q == StRun);
    // The cycle enable drops is still RUN but must not accept.
    push       = bus.valid_in && in_run && enable_in && accept_ok;
    drop       = bus.valid_in && in_run && !push;
  end

  // Next-state for FSM, pointers, count and status counters.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d      = count_q + OccW'(push) - OccW'(pop);
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = overflow_q;
    frame_done_d = pop && head_eof;

    if (drop) begin
      overflow_d = 1'b1;
      if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (enable_in) begin
          state_d    = StRun;
          drop_cnt_d = '0;
          overflow_d = 1'b0;
        end
      end
      StRun: begin
        if (!enable_in) state_d = StDrain;
      end
      StDrain: begin
        // Re-enable wins over finishing the drain; counters are kept.
        if (enable_in) begin
          state_d = StRun;
        end else if (count_q == '0 || (count_q == OccW'(1) && pop)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // All scheduler state; async assert, sync release handled by the reset tree.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Head is masked while empty so stale storage never shows after reset.
  always_comb begin
    bus.valid_out  = head_valid;
    bus.eof_out    = head_valid && head_eof;
    bus.vector_out = head_valid ? vec_t'(head_vec) : '0;
    occupancy_out  = count_q;
    drop_count_out = drop_cnt_q;
    overflow_out   = overflow_q;
    frame_done_out = frame_done_q;
  end

endmodule

// File: tb/tb_input_buffer_sched.sv
// Scoreboard bench for input_buffer_sched: directed stimulus pushes expected
// entries into a queue, a negedge monitor pops and compares on each handshake.
module tb_input_buffer_sched;
  import ib_sched_pkg::*;

  localparam int unsigned N     = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DROPW = 2;
  localparam int unsigned OCCW  = $clog2(DEPTH + 1);

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct packed {
    logic eof;
    vec_t vec;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [OCCW-1:0]  occupancy;
  logic [DROPW-1:0] drop_count;
  logic overflow, frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  ent_t q[$];
  logic fd_exp = 1'b0;

  input_buffer_sched_if #(.N(N), .DATA_WIDTH(DW)) bus ();

  input_buffer_sched #(
    .N              (N),
    .DATA_WIDTH     (DW),
    .IB_DEPTH       (DEPTH),
    .DROP_CNT_WIDTH (DROPW)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .enable_in      (enable),
    .bus            (bus.slave),
    .occupancy_out  (occupancy),
    .drop_count_out (drop_count),
    .overflow_out   (overflow),
    .frame_done_out (frame_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int v);
    vec_t r;
    for (int l = 0; l < int'(N); l++) r[l] = DW'(v) ^ (DW'(l) << 16);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One source beat; the bench decides whether the buffer should keep it.
  task automatic drive(input logic eof, input int v, input bit exp_acc);
    ent_t e;
    bus.valid_in  = 1'b1;
    bus.eof_in    = eof;
    bus.vector_in = mk(v);
    @(posedge clk);
    #2;
    bus.valid_in  = 1'b0;
    bus.eof_in    = 1'b0;
    if (exp_acc) begin
      e.eof = eof;
      e.vec = mk(v);
      q.push_back(e);
    end
  endtask

  // Monitor: head vs scoreboard, valid vs queue occupancy, frame_done one cycle after eof pop.
  always @(negedge clk) begin
    logic fd_next;
    if (!rst_n) begin
      q.delete();
      fd_exp = 1'b0;
    end else begin
      check("frame_done", 32'(frame_done), 32'(fd_exp));
      check("valid_out", 32'(bus.valid_out), 32'(q.size() != 0));
      fd_next = 1'b0;
      if (bus.valid_out && bus.ready_in) begin
        if (q.size() == 0) begin
          check("pop_unexpected", 32'd1, 32'd0);
        end else begin
          check("head_eof", 32'(bus.eof_out), 32'(q[0].eof));
          n_tests++;
          if (bus.vector_out !== q[0].vec) begin
            n_fail++;
            $display("[TB] FAIL head_vec: got %0h expected %0h", bus.vector_out[0], q[0].vec[0]);
          end
          fd_next = q[0].eof;
          void'(q.pop_front());
        end
      end
      fd_exp = fd_next;
    end
  end

  initial begin
    int fd_cnt;
    bus.valid_in  = 1'b0;
    bus.eof_in    = 1'b0;
    bus.vector_in = '0;
    bus.ready_in  = 1'b0;

    // Reset state
    step(3);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_vec_zero", 32'(bus.vector_out == '0), 32'd1);
    rst_n = 1'b1;
    step(1);

    // Streaming pass-through at one vector per cycle
    enable = 1'b1;
    bus.ready_in = 1'b1;
    step(1);
    drive(1'b0, 'hA, 1'b1);
    check("t1_occ_a", 32'(occupancy), 32'd1);
    drive(1'b0, 'hB, 1'b1);
    check("t1_occ_b", 32'(occupancy), 32'd1);
    drive(1'b0, 'hC, 1'b1);
    check("t1_occ_c", 32'(occupancy), 32'd1);
    step(1);
    check("t1_occ_end", 32'(occupancy), 32'd0);
    check("t1_drop", 32'(drop_count), 32'd0);

    // Overflow with eof reservation: 3 stored, 2 dropped, eof takes the last slot
    bus.ready_in = 1'b0;
    drive(1'b0, 'h10, 1'b1);
    drive(1'b0, 'h11, 1'b1);
    drive(1'b0, 'h12, 1'b1);
    drive(1'b0, 'h13, 1'b0);
    drive(1'b0, 'h14, 1'b0);
    drive(1'b1, 'h15, 1'b1);
    check("t2_occ", 32'(occupancy), 32'd4);
    check("t2_drop", 32'(drop_count), 32'd2);
    check("t2_ovf", 32'(overflow), 32'd1);
    bus.ready_in = 1'b1;
    fd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (frame_done) fd_cnt++;
    end
    check("t2_fd_pulses", 32'(fd_cnt), 32'd1);
    check("t2_occ_end", 32'(occupancy), 32'd0);

    // Push against a pop at full (dropped) and at count 3 (accepted)
    bus.ready_in = 1'b0;
    drive(1'b0, 'h20, 1'b1);
    drive(1'b0, 'h21, 1'b1);
    drive(1'b0, 'h22, 1'b1);
    drive(1'b1, 'h23, 1'b1);
    check("t3_occ_full", 32'(occupancy), 32'd4);
    bus.ready_in = 1'b1;
    drive(1'b0, 'h24, 1'b0);
    check("t3_drop", 32'(drop_count), 32'd3);
    check("t3_occ_after_drop", 32'(occupancy), 32'd3);
    drive(1'b0, 'h25, 1'b1);
    check("t3_occ_pushpop", 32'(occupancy), 32'd3);
    step(4);
    check("t3_occ_end", 32'(occupancy), 32'd0);

    // Disable with empty buffer, then re-enable clears the counters
    enable = 1'b0;
    step(2);
    check("t4a_idle", 32'(dut.state_q == StIdle), 32'd1);
    enable = 1'b1;
    step(1);
    check("t4a_drop_clr", 32'(drop_count), 32'd0);
    check("t4a_ovf_clr", 32'(overflow), 32'd0);

    // Drain: ignored inputs, drain to IDLE, re-enable clears
    bus.ready_in = 1'b0;
    drive(1'b0, 'h30, 1'b1);
    drive(1'b0, 'h31, 1'b1);
    drive(1'b0, 'h32, 1'b1);
    drive(1'b0, 'h33, 1'b0);
    check("t4_drop_pre", 32'(drop_count), 32'd1);
    enable = 1'b0;
    step(1);
    drive(1'b0, 'h34, 1'b0);
    drive(1'b1, 'h35, 1'b0);
    check("t4_drain_state", 32'(dut.state_q == StDrain), 32'd1);
    check("t4_drain_occ", 32'(occupancy), 32'd3);
    check("t4_drain_drop", 32'(drop_count), 32'd1);
    bus.ready_in = 1'b1;
    step(3);
    check("t4_occ_end", 32'(occupancy), 32'd0);
    check("t4_idle", 32'(dut.state_q == StIdle), 32'd1);
    check("t4_ovf_kept", 32'(overflow), 32'd1);
    enable = 1'b1;
    step(1);
    check("t4_drop_clr", 32'(drop_count), 32'd0);
    check("t4_ovf_clr", 32'(overflow), 32'd0);

    // Drop counter saturation: 9 non-eof into 4 slots -> 6 drops, 2-bit counter holds 3
    bus.ready_in = 1'b0;
    for (int i = 0; i < 9; i++) drive(1'b0, 'h40 + i, i < 3);
    check("t5_drop_sat", 32'(drop_count), 32'd3);
    check("t5_occ", 32'(occupancy), 32'd3);
    check("t5_ovf", 32'(overflow), 32'd1);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    q.delete();
    #1;
    check("t6_valid", 32'(bus.valid_out), 32'd0);
    check("t6_occ", 32'(occupancy), 32'd0);
    check("t6_fd", 32'(frame_done), 32'd0);
    check("t6_drop", 32'(drop_count), 32'd0);
    check("t6_vec_zero", 32'(bus.vector_out == '0), 32'd1);
    step(2);
    rst_n = 1'b1;
    bus.ready_in = 1'b1;
    step(4);
    check("t6_valid_after", 32'(bus.valid_out), 32'd0);
    check("t6_occ_after", 32'(occupancy), 32'd0);
    check("t6_q_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
